// File: rtl/store_queue_ctrl_pkg.sv
// Shared types for the store queue / D-cache port scheduler.
// Holds the scheduler state encoding, the queue entry layout and the default depth.
package mips_core_pkg;

  localparam int STORE_QUEUE_DEPTH = 4;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } sq_state_t;

  // Word-granular entry: byte offset is dropped on enqueue.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } sq_entry_t;

endpackage

// File: rtl/store_queue_ctrl_if.sv
// D-cache request/response port. The controller is the master; the cache is the slave.
interface store_queue_ctrl_if;
  logic        o_req_valid;
  logic        o_req_action;
  logic [31:0] o_req_addr;
  logic [31:0] o_req_data;
  logic        i_resp_valid;

  modport master (output o_req_valid, o_req_action, o_req_addr, o_req_data,
                  input  i_resp_valid);
  modport slave  (input  o_req_valid, o_req_action, o_req_addr, o_req_data,
                  output i_resp_valid);
endinterface

// File: rtl/store_queue_ctrl_fwd_match.sv
// DEPTH-way word-address compare over the live queue window [head, head+count).
// Youngest (closest to tail) matching entry wins.
module store_queue_fwd_match
  import mips_core_pkg::*;
#(
  parameter int DEPTH = STORE_QUEUE_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sq_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         head,
  input  logic [PW:0]           count,
  input  logic [29:0]           waddr,
  output logic                  hit,
  output logic [PW-1:0]         hit_idx,
  output logic [31:0]           hit_data
);

  logic [DEPTH-1:0] match;

  // Per-entry compare, qualified by the entry lying inside the live window.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PW-1:0] age;
    assign age      = PW'(i) - head;
    assign match[i] = ({1'b0, age} < count) && (entries[i].waddr == waddr);
  end

  // Walk oldest to youngest so the last hit seen is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head + PW'(k)]) begin
        hit     = 1'b1;
        hit_idx = head + PW'(k);
      end
    end
  end

  assign hit_data = entries[hit_idx].data;

endmodule

// File: rtl/store_queue_ctrl.sv
// Store queue + D-cache port scheduler.
// Optional feature macro: STORE_QUEUE_FORWARD_EN (store-to-load forwarding).
// Without it, a load hitting a queued store is held off until the store drains.
module store_queue_ctrl
  import mips_core_pkg::*;
#(
  parameter int DEPTH = STORE_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_write_valid,
  input  logic [31:0]              i_write_addr,
  input  logic [31:0]              i_write_data,
  output logic                     o_wrote,
  input  logic                     i_fwd_addr_valid,
  input  logic [31:0]              i_fwd_addr,
  output logic                     o_fwd_data_valid,
  output logic [31:0]              o_fwd_data,
  input  logic                     i_load_req_valid,
  input  logic [31:0]              i_load_addr,
  output logic                     o_load_grant,
  input  logic                     i_drain_all,
  store_queue_ctrl_if.master       dc,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  sq_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         head, tail;
  logic [PW:0]           count;
  sq_state_t             state;

  logic          full, empty, wr_en, retire, hazard;
  logic          sel_store, sel_load, do_store, do_load;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [31:0]   hit_data;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A slot freed by this cycle's retire is not visible to enqueue until next cycle.
  assign wr_en   = rst_n && i_write_valid && !full;
  assign o_wrote = wr_en;
  assign o_full  = rst_n && full;
  assign o_empty = !rst_n || empty;

`ifdef STORE_QUEUE_FORWARD_EN
  store_queue_fwd_match #(.DEPTH(DEPTH)) u_match (
    .entries (mem), .head(head), .count(count), .waddr(i_fwd_addr[31:2]),
    .hit(hit), .hit_idx(hit_idx), .hit_data(hit_data)
  );
  assign hazard           = 1'b0;
  assign o_fwd_data_valid = rst_n && i_fwd_addr_valid && hit;
  assign o_fwd_data       = o_fwd_data_valid ? hit_data : 32'h0;

  logic unused_ok;
  assign unused_ok = ^{i_write_addr[1:0], i_fwd_addr[1:0], hit_idx};
`else
  // Match against the pending load instead: a hit means the cache holds stale data.
  store_queue_fwd_match #(.DEPTH(DEPTH)) u_match (
    .entries (mem), .head(head), .count(count), .waddr(i_load_addr[31:2]),
    .hit(hit), .hit_idx(hit_idx), .hit_data(hit_data)
  );
  assign hazard           = i_load_req_valid && hit;
  assign o_fwd_data_valid = 1'b0;
  assign o_fwd_data       = 32'h0;

  logic unused_ok;
  assign unused_ok = ^{i_write_addr[1:0], i_fwd_addr, i_fwd_addr_valid, hit_idx, hit_data};
`endif

  // IDLE arbitration and per-state port ownership.
  always_comb begin
    sel_store = !empty && (full || i_drain_all || !i_load_req_valid || hazard);
    sel_load  = !sel_store && i_load_req_valid && !hazard;
    do_store  = 1'b0;
    do_load   = 1'b0;
    case (state)
      IDLE:    begin do_store = sel_store; do_load = sel_load; end
      LOAD:    do_load  = 1'b1;
      STORE:   do_store = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      do_store = 1'b0;
      do_load  = 1'b0;
    end
  end

  assign retire          = do_store && dc.i_resp_valid;
  assign o_load_grant    = do_load;
  assign dc.o_req_valid  = do_store || do_load;
  assign dc.o_req_action = do_store ? REQ_WRITE : REQ_READ;
  assign dc.o_req_addr   = do_store ? {mem[head].waddr, 2'b00} :
                           do_load  ? i_load_addr : 32'h0;
  assign dc.o_req_data   = do_store ? mem[head].data : 32'h0;

  // Scheduler: a started transaction is held until the cache responds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!dc.i_resp_valid) begin
            if (sel_store)     state <= STORE;
            else if (sel_load) state <= LOAD;
          end
        end
        LOAD:    if (dc.i_resp_valid) state <= IDLE;
        STORE:   if (dc.i_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en)  tail <= tail + 1'b1;
      if (retire) head <= head + 1'b1;
      count <= count + (PW+1)'(wr_en) - (PW+1)'(retire);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= '{waddr: i_write_addr[31:2], data: i_write_data};
  end

endmodule

// File: doc/store_queue_ctrl.md
# store_queue_ctrl

Word-granular store queue plus D-cache port scheduler sitting between the load/store execution unit and the D-cache. Accepts committed stores from the execution unit, buffers them in a circular FIFO, and drains them to the D-cache when the single cache port is not serving a load. Provides youngest-match store-to-load forwarding so loads never read stale data. Owns all arbitration of the D-cache request port.

## Interface
- `DEPTH`, default 4: number of store entries; power of two, minimum 2.
- `clk`  in  1  core clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_write_valid`  in  1  execution unit presents a store.
- `i_write_addr`  in  32  store byte address.
- `i_write_data`  in  32  store word.
- `o_wrote`  out  1  store accepted this cycle.
- `i_fwd_addr_valid`  in  1  forwarding lookup is active (load in EX).
- `i_fwd_addr`  in  32  load address for lookup.
- `o_fwd_data_valid`  out  1  youngest matching entry found.
- `o_fwd_data`  out  32  data of that entry.
- `i_load_req_valid`  in  1  execution unit wants the cache for a load.
- `i_load_addr`  in  32  load address.
- `o_load_grant`  out  1  cache port currently owned by the load.
- `i_drain_all`  in  1  drain request (fence/syscall); raises store priority.
- `o_req_valid`  out  1  D-cache request valid.
- `o_req_action`  out  1  READ=0, WRITE=1.
- `o_req_addr`  out  32  D-cache address.
- `o_req_data`  out  32  D-cache write data.
- `i_resp_valid`  in  1  D-cache completes the current request.
- `o_empty`  out  1  queue holds no entries.
- `o_full`  out  1  count == DEPTH.

## Operation
- Storage: DEPTH entries {addr[31:2], data}; head/tail pointers of log2(DEPTH) bits wrap naturally; count of log2(DEPTH)+1 bits.
- Enqueue: `o_wrote` = `i_write_valid` && !`o_full` (combinational). Slot freed in the same cycle is not reusable that cycle.
- Forwarding: compare `i_fwd_addr[31:2]` against every valid entry; youngest (closest to tail) match wins. Entry being drained still matches until it retires.
- Scheduler FSM: IDLE, LOAD, STORE.
  - IDLE: select store if count>0 and (`o_full` or `i_drain_all` or !`i_load_req_valid`); else load if `i_load_req_valid`. Selected request is driven combinationally. If `i_resp_valid` is seen the same cycle, transaction completes and state stays IDLE; otherwise move to LOAD/STORE.
  - LOAD: hold `o_req_*` = load, `o_load_grant`=1; on `i_resp_valid` -> IDLE.
  - STORE: hold head entry as WRITE; on `i_resp_valid` pop head -> IDLE.
- Load and store are never both granted; a transaction is never abandoned until `i_resp_valid`.
- Simultaneous enqueue and retire: count unchanged, both pointers advance.
- Load whose forward hits still goes through arbitration only if the execution unit requests it; controller does not suppress `i_load_req_valid`.

## Timing
- Reset (rst_n low at posedge): head=tail=count=0, state IDLE, entry contents don't-care. While rst_n low all outputs are 0 except `o_empty`=1. Reset mid-transaction drops the transaction and all queued stores.
- Enqueue: visible to forwarding and arbitration the cycle after `o_wrote`.
- Minimum drain latency: enqueue at cycle N, WRITE request at N+1, retire on the cycle `i_resp_valid` is high.
- Forward path and request outputs are combinational from registered state plus current inputs; no registered output.

## Configuration
- `STORE_QUEUE_FORWARD_EN` defined: forwarding as above.
- Undefined: `o_fwd_data_valid`=0, `o_fwd_data`=0; match logic still computes a hazard, and in IDLE a load whose address matches any entry is not granted; stores drain with priority until no match remains.

## Structure
- Shared package `mips_core_pkg`: `sq_state_t` enum {IDLE, LOAD, STORE}, `sq_entry_t` struct {word address, data}, `STORE_QUEUE_DEPTH` default constant.
- One sub-module: `store_queue_fwd_match` — DEPTH-way compare with youngest-first priority, outputs hit flag, hit index and data.

## Test plan
- Enqueue 0x100<-0xAAAA, 0x100<-0xBBBB, lookup 0x102 -> `o_fwd_data_valid`=1, data 0xBBBB.
- Fill DEPTH stores with `i_load_req_valid` held high -> 5th store gets `o_wrote`=0; `o_full` forces WRITE request for head in IDLE before the load.
- Load requested, resp after 3 cycles while store enqueued -> `o_load_grant` held 3 cycles, WRITE issued only next IDLE cycle.
- Same-cycle enqueue and retire with count=2 -> count stays 2, tail/head each advance, pointers wrap at DEPTH.
- rst_n low during STORE state with 3 entries -> next cycle `o_empty`=1, `o_req_valid`=0, state IDLE.
- Without `STORE_QUEUE_FORWARD_EN`: store 0x200 queued, load 0x200 requested -> WRITE issued first, READ granted only after retire.
